// File: rtl/spi_periph_pkg.sv
// Shared types and helpers for the SPI register-file peripheral.
// Frame layout: R/W bit, then the address field, then the data field, MSB first.
package spi_periph_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    function automatic int frame_len(input int addrW, input int dataW);
        return 1 + addrW + dataW;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin.
// Provides the synchronised level plus one-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // prev_q shares the reset value so that leaving reset never fakes an edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 peripheral exposing a generic register file with read-back,
// abort detection and a one-cycle write-commit strobe.
module spi_regfile_periph
    import spi_periph_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       SCLK,
    input  logic                       COPI,
    input  logic                       nCS,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    localparam int FRAME    = frame_len(ADDR_W, DATA_W);
    localparam int CMD_BITS = 1 + ADDR_W;
    localparam int CNT_W    = $clog2(FRAME + 1);
    localparam int SHIFT_W  = ((CMD_BITS > DATA_W) ? CMD_BITS : DATA_W) - 1;

    logic sclkLevel, sclkRise, sclkFall;
    logic csLevel, csRise, csFall;
    logic copiLevel, unusedCopiRise, unusedCopiFall, unusedSclkLevel;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .async_i (SCLK),
        .level_o (unusedSclkLevel),
        .rise_o  (sclkRise),
        .fall_o  (sclkFall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .async_i (nCS),
        .level_o (csLevel),
        .rise_o  (csRise),
        .fall_o  (csFall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .async_i (COPI),
        .level_o (copiLevel),
        .rise_o  (unusedCopiRise),
        .fall_o  (unusedCopiFall)
    );

    assign sclkLevel = unusedSclkLevel;

    state_e                  state_q;
    logic [CNT_W-1:0]        bitCnt_q;
    logic [SHIFT_W-1:0]      shift_q;
    logic                    rw_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       data_q;
    logic [DATA_W-1:0]       readShift_q;
    logic                    commit_q;
    logic                    cipo_q;
    logic                    cipoOe_q;
    logic                    wrStrobe_q;
    logic [ADDR_W-1:0]       wrAddr_q;
    logic                    frameErr_q;
    logic [DATA_W-1:0]       regs_q [NUM_REGS];

    logic [CMD_BITS-1:0]     cmdWord;
    logic [DATA_W-1:0]       dataWord;
    logic [ADDR_W-1:0]       cmdAddr;
    logic [DATA_W-1:0]       readSel;
    logic                    addrInRange;

    // The bit arriving on this rising edge completes the shifted word
    assign cmdWord  = {shift_q[CMD_BITS-2:0], copiLevel};
    assign dataWord = {shift_q[DATA_W-2:0], copiLevel};
    assign cmdAddr  = cmdWord[ADDR_W-1:0];

    // Unimplemented addresses read back as zero
    always_comb begin
        readSel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cmdAddr == ADDR_W'(i)) begin
                readSel = regs_q[i];
            end
        end
    end

    assign addrInRange = ({1'b0, addr_q} < (ADDR_W + 1)'(NUM_REGS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            rw_q        <= RW_READ;
            addr_q      <= '0;
            data_q      <= '0;
            readShift_q <= '0;
            commit_q    <= 1'b0;
            cipo_q      <= 1'b0;
            cipoOe_q    <= 1'b0;
            wrStrobe_q  <= 1'b0;
            wrAddr_q    <= '0;
            frameErr_q  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wrStrobe_q <= 1'b0;
            frameErr_q <= 1'b0;
            cipoOe_q   <= ~csLevel;

            if (commit_q) begin
                commit_q <= 1'b0;
                if (addrInRange) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (addr_q == ADDR_W'(i)) begin
                            regs_q[i] <= data_q;
                        end
                    end
                    wrAddr_q   <= addr_q;
                    wrStrobe_q <= 1'b1;
                end
            end

            if (csFall) begin
                state_q     <= CMD;
                bitCnt_q    <= '0;
                shift_q     <= '0;
                readShift_q <= '0;
                cipo_q      <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                    end

                    CMD: begin
                        if (csRise) begin
                            state_q    <= IDLE;
                            frameErr_q <= 1'b1;
                        end else if (sclkRise) begin
                            bitCnt_q <= bitCnt_q + CNT_W'(1);
                            if (bitCnt_q == CNT_W'(CMD_BITS - 1)) begin
                                rw_q        <= cmdWord[CMD_BITS-1];
                                addr_q      <= cmdAddr;
                                readShift_q <= (cmdWord[CMD_BITS-1] == RW_READ) ? readSel : '0;
                                shift_q     <= '0;
                                state_q     <= DATA;
                            end else begin
                                shift_q <= {shift_q[SHIFT_W-2:0], copiLevel};
                            end
                        end
                    end

                    DATA: begin
                        if (csRise) begin
                            state_q    <= IDLE;
                            frameErr_q <= 1'b1;
                        end else if (sclkRise) begin
                            bitCnt_q <= bitCnt_q + CNT_W'(1);
                            shift_q  <= {shift_q[SHIFT_W-2:0], copiLevel};
                            if (bitCnt_q == CNT_W'(FRAME - 1)) begin
                                data_q   <= dataWord;
                                commit_q <= (rw_q == RW_WRITE);
                                state_q  <= DONE;
                            end
                        end else if (sclkFall && (rw_q == RW_READ)) begin
                            cipo_q      <= readShift_q[DATA_W-1];
                            readShift_q <= {readShift_q[DATA_W-2:0], 1'b0};
                        end
                    end

                    DONE: begin
                        // Surplus SCLKs are absorbed here; the counter parks at FRAME
                        if (csRise) begin
                            state_q <= IDLE;
                        end else begin
                            if (sclkRise && (bitCnt_q != CNT_W'(FRAME))) begin
                                bitCnt_q <= bitCnt_q + CNT_W'(1);
                            end
                            if (sclkFall) begin
                                cipo_q <= 1'b0;
                            end
                        end
                    end

                    default: state_q <= IDLE;
                endcase
            end

            if (csLevel) begin
                cipo_q <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign cipo      = cipo_q & cipoOe_q & ~(sclkLevel & 1'b0);
    assign cipo_oe   = cipoOe_q;
    assign wr_strobe = wrStrobe_q;
    assign wr_addr   = wrAddr_q;
    assign frame_err = frameErr_q;

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Directed table-driven bench for spi_regfile_periph, plus hand-written
// sequences for the coincident-abort and mid-frame-reset corner cases.
module tb_spi_regfile_periph;

    localparam int HALF = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        SCLK;
    logic        COPI;
    logic        nCS;
    logic        cipo;
    logic        cipo_oe;
    logic [39:0] regs_flat;
    logic        wr_strobe;
    logic [6:0]  wr_addr;
    logic        frame_err;

    int nVec = 0;
    int nBad = 0;
    int strobeCnt = 0;
    int errCnt = 0;

    spi_regfile_periph dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SCLK      (SCLK),
        .COPI      (COPI),
        .nCS       (nCS),
        .cipo      (cipo),
        .cipo_oe   (cipo_oe),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Pulse widths are measured in clk cycles, sampled away from the active edge
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) strobeCnt++;
        if (frame_err === 1'b1) errCnt++;
    end

    typedef struct {
        string       name;
        logic [15:0] frame;
        int          nbits;
        int          extra;
        bit          isRead;
        logic [39:0] expRegs;
        logic [6:0]  expWrAddr;
        int          expStrobes;
        int          expErrs;
        logic [7:0]  expRead;
    } vec_t;

    vec_t vecs[9];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nBad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // mode 0: normal end, 1: nCS rises with the last SCLK rise, 2: leave nCS low
    task automatic applyStimulus(input logic [15:0] frame, input int nbits, input int extra,
                                 input int mode, output logic [7:0] rdata,
                                 output bit extraBad, output bit oeBad, output bit oeAfter);
        strobeCnt = 0;
        errCnt    = 0;
        rdata     = '0;
        extraBad  = 1'b0;
        oeBad     = 1'b0;
        oeAfter   = 1'b0;
        nCS = 1'b0;
        #60;
        for (int b = 0; b < nbits + extra; b++) begin
            COPI = (b < 16) ? frame[15-b] : 1'b0;
            #(HALF);
            if (b >= 8 && b < 16) rdata = {rdata[6:0], cipo};
            if (b >= 16 && cipo !== 1'b0) extraBad = 1'b1;
            if (cipo_oe !== 1'b1) oeBad = 1'b1;
            SCLK = 1'b1;
            if (mode == 1 && b == nbits - 1) nCS = 1'b1;
            #(HALF);
            SCLK = 1'b0;
        end
        if (mode != 2) begin
            if (mode == 0) begin
                #(HALF);
                nCS = 1'b1;
            end
            #100;
            oeAfter = cipo_oe | cipo;
        end
    endtask

    initial begin
        logic [7:0] rdata;
        bit extraBad, oeBad, oeAfter;

        vecs[0] = '{"wr reg0",        16'h80F0, 16, 0, 1'b0, 40'h00_00_00_00_F0, 7'd0, 1, 0, 8'h00};
        vecs[1] = '{"wr reg4",        16'h84A5, 16, 0, 1'b0, 40'hA5_00_00_00_F0, 7'd4, 1, 0, 8'h00};
        vecs[2] = '{"rd reg4",        16'h0400, 16, 0, 1'b1, 40'hA5_00_00_00_F0, 7'd4, 0, 0, 8'hA5};
        vecs[3] = '{"wr addr16",      16'h903C, 16, 0, 1'b0, 40'hA5_00_00_00_F0, 7'd4, 0, 0, 8'h00};
        vecs[4] = '{"rd addr16",      16'h1000, 16, 0, 1'b1, 40'hA5_00_00_00_F0, 7'd4, 0, 0, 8'h00};
        vecs[5] = '{"abort 10 bits",  16'h81FF, 10, 0, 1'b0, 40'hA5_00_00_00_F0, 7'd4, 0, 1, 8'h00};
        vecs[6] = '{"wr reg1",        16'h810F, 16, 0, 1'b0, 40'hA5_00_00_0F_F0, 7'd1, 1, 0, 8'h00};
        vecs[7] = '{"wr reg2 extra",  16'h8255, 16, 4, 1'b0, 40'hA5_00_55_0F_F0, 7'd2, 1, 0, 8'h00};
        vecs[8] = '{"rd reg1 extra",  16'h0100, 16, 2, 1'b1, 40'hA5_00_55_0F_F0, 7'd2, 0, 0, 8'h0F};

        rst_n = 1'b0;
        nCS   = 1'b1;
        SCLK  = 1'b0;
        COPI  = 1'b0;
        #40;
        rst_n = 1'b1;
        #40;
        checkOutput("reset regs",    regs_flat, 40'h0);
        checkOutput("reset cipo_oe", cipo_oe,   0);
        checkOutput("reset wr_addr", wr_addr,   0);
        checkOutput("reset strobe",  wr_strobe, 0);

        for (int v = 0; v < 9; v++) begin
            applyStimulus(vecs[v].frame, vecs[v].nbits, vecs[v].extra, 0, rdata, extraBad, oeBad, oeAfter);
            checkOutput({vecs[v].name, " regs"},    regs_flat, vecs[v].expRegs);
            checkOutput({vecs[v].name, " wr_addr"}, wr_addr,   vecs[v].expWrAddr);
            checkOutput({vecs[v].name, " strobes"}, strobeCnt, vecs[v].expStrobes);
            checkOutput({vecs[v].name, " errs"},    errCnt,    vecs[v].expErrs);
            checkOutput({vecs[v].name, " oe low"},  oeBad,     0);
            checkOutput({vecs[v].name, " oe off"},  oeAfter,   0);
            if (vecs[v].isRead) begin
                checkOutput({vecs[v].name, " rdata"}, rdata, vecs[v].expRead);
            end
            if (vecs[v].extra > 0) begin
                checkOutput({vecs[v].name, " cipo extra"}, extraBad, 0);
            end
        end

        $display("[TB] coincident nCS rise on final SCLK rise");
        applyStimulus(16'h8377, 16, 0, 1, rdata, extraBad, oeBad, oeAfter);
        checkOutput("coinc regs",    regs_flat, 40'hA5_00_55_0F_F0);
        checkOutput("coinc strobes", strobeCnt, 0);
        checkOutput("coinc errs",    errCnt,    1);

        $display("[TB] reset after 12 bits");
        applyStimulus(16'h83AA, 12, 0, 2, rdata, extraBad, oeBad, oeAfter);
        #20;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst regs",    regs_flat, 40'h0);
        checkOutput("midrst cipo_oe", cipo_oe,   0);
        checkOutput("midrst cipo",    cipo,      0);
        checkOutput("midrst wr_addr", wr_addr,   0);
        checkOutput("midrst err",     frame_err, 0);
        #9;
        nCS = 1'b1;
        #40;
        rst_n = 1'b1;
        #40;
        applyStimulus(16'h8399, 16, 0, 0, rdata, extraBad, oeBad, oeAfter);
        checkOutput("postrst regs",    regs_flat, 40'h00_99_00_00_00);
        checkOutput("postrst wr_addr", wr_addr,   3);
        checkOutput("postrst strobes", strobeCnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule

// File: doc/spi_regfile_periph.md
Name: spi_regfile_periph

Overview:
Parametrised SPI mode-0 peripheral, successor to the fixed five-register write-only SPI block. Exposes a generic register file of NUM_REGS registers, each DATA_W bits wide, over a flattened output bus.
- Adds read-back on CIPO, abort detection and a write-commit strobe.
- Sits between the chip pins and the PWM/output-enable logic.
- The system clock is oversampled relative to SCLK.

Parameters:
ADDR_W, 7, address field width in bits
DATA_W, 8, register and data-field width in bits
NUM_REGS, 5, number of implemented registers (1..2**ADDR_W)
SYNC_STAGES, 2, synchroniser depth for SCLK/COPI/nCS (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
SCLK  in  1  SPI clock, async, idle low
COPI  in  1  controller-out data, async
nCS  in  1  active-low chip select, async
cipo  out  1  peripheral-out data
cipo_oe  out  1  CIPO output enable
regs_flat  out  NUM_REGS*DATA_W  register file; reg i at bits [i*DATA_W +: DATA_W]
wr_strobe  out  1  one-cycle pulse on each committed in-range write
wr_addr  out  ADDR_W  address of the last committed write
frame_err  out  1  one-cycle pulse on an aborted frame

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all registers 0, cipo 0, cipo_oe 0, wr_strobe 0, wr_addr 0, frame_err 0, FSM IDLE. The synchroniser resets nCS to 1 and SCLK/COPI to 0.
- Frame format: FRAME = 1+ADDR_W+DATA_W bits, MSB first.
  - Bit 0 is R/W (1 = write).
  - Next ADDR_W bits are the address; final DATA_W bits are data.
- Edges: derived from the synchronised signals only.
  - COPI is sampled on the rising SCLK edge.
  - cipo updates on the falling SCLK edge.
- Clock ratio requirement: clk >= 8x SCLK.
- FSM states:
  - IDLE: wait for nCS fall. On fall, clear the bit counter and shift register, go to CMD.
  - CMD: shift 1+ADDR_W bits. After the last address bit:
    - Latch rw and addr.
    - For a read, load the read shift register with reg[addr], or 0 if addr >= NUM_REGS.
    - Go to DATA.
  - DATA: shift DATA_W bits.
    - Read: each falling edge presents the next bit of the read shift register on cipo, MSB first. The MSB appears on the falling edge after the last address bit.
    - Write: after the final rising edge, go to DONE.
  - DONE (write frames):
    - In the cycle after entry, if addr < NUM_REGS: reg[addr] <= data, wr_addr <= addr, wr_strobe = 1 for exactly one cycle.
    - Out-of-range write: no register change, no strobe.
    - Then wait for nCS rise and go to IDLE. Read frames also go to DONE after the final bit.
- cipo_oe = 1 while synchronised nCS is low. cipo = 0 whenever cipo_oe = 0.
- Write bits received in DONE: ignored, no second commit. Read frames with extra SCLKs: cipo = 0 after the last data bit.
- Abort: nCS rise in CMD or DATA returns the FSM to IDLE, pulses frame_err for one cycle, changes no registers and gives no wr_strobe.
  - If nCS rises in the same clk cycle as the final rising SCLK edge, nCS rise wins and the frame is aborted.
- The nCS fall handler always restarts framing, regardless of state.
- Reset mid-frame: immediate return to reset values. A partial frame is never committed.
- Counter width: $clog2(FRAME+1). It saturates and never wraps.

Decomposition:
- Package spi_periph_pkg:
  - state enum (IDLE, CMD, DATA, DONE)
  - R/W bit encoding constants
  - function frame_len(ADDR_W, DATA_W)
- Sub-module spi_sync_edge: SYNC_STAGES-flop synchroniser with rise/fall pulse outputs and parametrised reset value.
  - Instantiated for SCLK, nCS and COPI; the COPI instance uses the level only.

Test Plan:
- Write frame 0x80,0xF0 -> reg0 = 0xF0; wr_strobe high exactly 1 cycle; wr_addr = 0; other regs 0.
- Write 0x84,0xA5, then read frame 0x04,0x00 -> cipo shows 1,0,1,0,0,1,0,1 on successive falling edges; cipo_oe high only during nCS low.
- Write 0x90,0x3C (addr 0x10 >= NUM_REGS) -> no reg change, no wr_strobe. Read of 0x10 -> 0x00 on cipo.
- Raise nCS after 10 bits of write 0x81,0xFF -> reg1 unchanged, frame_err 1-cycle pulse. Following full write 0x81,0x0F -> reg1 = 0x0F.
- Write 0x82,0x55 followed by 4 extra SCLKs before nCS rise -> reg2 = 0x55, single wr_strobe. nCS rise coincident with the 16th rising edge -> abort, frame_err pulse.
- Assert rst_n low after 12 bits -> all outputs 0 immediately. After release, a full write 0x83,0x99 -> reg3 = 0x99.
